// File: rtl/rx_data_recovery_if.sv
// Signal bundle between the receive FSM (master) and the data recovery block (slave).
interface rx_data_recovery_if;
  logic       i_rxd;
  logic       i_sampling_en;
  logic       i_bit_counter_load_en;
  logic       i_start_bit_wait;
  logic       i_data_bit_wait;
  logic       i_parity_check;
  logic       i_stop_bit_wait;
  logic [2:0] i_ucsz;
  logic       i_upm1;
  logic       i_upm0;
  logic       o_edge_detect;
  logic       o_start_bit;
  logic       o_data_recovery;
  logic       o_end_frame;
  logic       o_rx_bit;
  logic [8:0] o_rx_data;
  logic       o_parity_error;
  logic       o_frame_error;

  modport master (
    output i_rxd, i_sampling_en, i_bit_counter_load_en, i_start_bit_wait,
           i_data_bit_wait, i_parity_check, i_stop_bit_wait, i_ucsz, i_upm1, i_upm0,
    input  o_edge_detect, o_start_bit, o_data_recovery, o_end_frame, o_rx_bit,
           o_rx_data, o_parity_error, o_frame_error
  );

  modport slave (
    input  i_rxd, i_sampling_en, i_bit_counter_load_en, i_start_bit_wait,
           i_data_bit_wait, i_parity_check, i_stop_bit_wait, i_ucsz, i_upm1, i_upm0,
    output o_edge_detect, o_start_bit, o_data_recovery, o_end_frame, o_rx_bit,
           o_rx_data, o_parity_error, o_frame_error
  );
endinterface

// File: rtl/rx_data_recovery.sv
// UART receive bit recovery: line sync, 16x mid-bit sampling, character assembly, parity/frame checks.
// Define RX_MAJORITY_VOTE_EN to recover each bit as the 2-of-3 vote of the three mid-bit samples.
module rx_data_recovery #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           i_rxclk,
  input  logic           i_rst,
  rx_data_recovery_if.slave rx
);

  localparam int                CNT_W  = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  S_MID  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0]  S_LATE = CNT_W'(OVERSAMPLE / 2 + 1);

  function automatic logic [3:0] char_len(input logic [2:0] ucsz);
    case (ucsz)
      3'b000:  char_len = 4'd5;
      3'b001:  char_len = 4'd6;
      3'b010:  char_len = 4'd7;
      3'b111:  char_len = 4'd9;
      default: char_len = 4'd8;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  logic             rxd_sync_p0, rxd_sync_p1, rxd_hist_p2;
  logic [CNT_W-1:0] samp_cnt;
  logic             samp_mid_p1;
  logic             rec_pend_p1;
  logic             rec_bit;
  logic [3:0]       bit_idx;
  logic             par_acc;
  logic [3:0]       char_n;
  logic             unused_upm1;

  assign char_n      = char_len(rx.i_ucsz);
  assign unused_upm1 = rx.i_upm1;

  // Stage 0-2: synchroniser and history; flops idle high so reset release never looks like a start edge
  always_ff @(posedge i_rxclk or posedge i_rst) begin
    if (i_rst) begin
      rxd_sync_p0      <= 1'b1;
      rxd_sync_p1      <= 1'b1;
      rxd_hist_p2      <= 1'b1;
      rx.o_edge_detect <= 1'b0;
    end else begin
      rxd_sync_p0      <= rx.i_rxd;
      rxd_sync_p1      <= rxd_sync_p0;
      rxd_hist_p2      <= rxd_sync_p1;
      rx.o_edge_detect <= rxd_hist_p2 & ~rxd_sync_p1;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CNT_W-1:0] S_EARLY = CNT_W'(OVERSAMPLE / 2 - 1);
  logic samp_early_p1, samp_late_p1;

  always_ff @(posedge i_rxclk or posedge i_rst) begin
    if (i_rst) begin
      samp_early_p1 <= 1'b1;
      samp_late_p1  <= 1'b1;
    end else if (rx.i_sampling_en) begin
      if (samp_cnt == S_EARLY) samp_early_p1 <= rxd_sync_p1;
      if (samp_cnt == S_LATE)  samp_late_p1  <= rxd_sync_p1;
    end
  end

  assign rec_bit = maj3(samp_early_p1, samp_mid_p1, samp_late_p1);
`else
  assign rec_bit = samp_mid_p1;
`endif

  // Stage 1: free-running sample counter and mid-bit capture
  always_ff @(posedge i_rxclk or posedge i_rst) begin
    if (i_rst) begin
      samp_cnt    <= '0;
      samp_mid_p1 <= 1'b1;
      rec_pend_p1 <= 1'b0;
    end else begin
      samp_cnt    <= rx.i_sampling_en ? samp_cnt + 1'b1 : '0;
      rec_pend_p1 <= rx.i_sampling_en && (samp_cnt == S_LATE);
      if (rx.i_sampling_en && (samp_cnt == S_MID)) samp_mid_p1 <= rxd_sync_p1;
    end
  end

  // Stage 2: bit recovery and phase-dependent side effects; a frame load discards a coincident bit
  always_ff @(posedge i_rxclk or posedge i_rst) begin
    if (i_rst) begin
      rx.o_data_recovery <= 1'b0;
      rx.o_start_bit     <= 1'b0;
      rx.o_end_frame     <= 1'b0;
      rx.o_rx_bit        <= 1'b0;
      rx.o_rx_data       <= '0;
      rx.o_parity_error  <= 1'b0;
      rx.o_frame_error   <= 1'b0;
      bit_idx            <= '0;
      par_acc            <= 1'b0;
    end else begin
      rx.o_data_recovery <= rec_pend_p1;
      rx.o_start_bit     <= 1'b0;
      rx.o_end_frame     <= 1'b0;
      if (rec_pend_p1) rx.o_rx_bit <= rec_bit;
      if (rx.i_bit_counter_load_en) begin
        bit_idx           <= '0;
        par_acc           <= 1'b0;
        rx.o_rx_data      <= '0;
        rx.o_parity_error <= 1'b0;
        rx.o_frame_error  <= 1'b0;
      end else if (rec_pend_p1) begin
        if (rx.i_start_bit_wait) rx.o_start_bit <= ~rec_bit;
        if (rx.i_data_bit_wait) begin
          if (bit_idx < char_n) rx.o_rx_data[bit_idx] <= rec_bit;
          par_acc        <= par_acc ^ rec_bit;
          rx.o_end_frame <= (bit_idx == char_n - 4'd1);
          if (bit_idx != 4'd8) bit_idx <= bit_idx + 4'd1;
        end
        if (rx.i_parity_check && (rec_bit ^ par_acc ^ rx.i_upm0)) rx.o_parity_error <= 1'b1;
        if (rx.i_stop_bit_wait && !rec_bit) rx.o_frame_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_data_recovery.sv
// Bench for rx_data_recovery: serial frame driver, small receive FSM, scoreboard of expected recoveries.
module tb_rx_data_recovery;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_data_recovery_if ifc();

  rx_data_recovery #(.OVERSAMPLE(16)) dut (
    .i_rxclk(clk),
    .i_rst  (rst),
    .rx     (ifc.slave)
  );

  typedef struct packed {
    logic       bitv;
    logic       startb;
    logic       endf;
    logic       chk;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  typedef enum {F_IDLE, F_START, F_DATA, F_PAR, F_STOP} fsm_t;
  fsm_t fst = F_IDLE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic s, input logic e, input logic c,
                              input logic [8:0] d, input logic pe, input logic fe);
    exp_t r;
    r.bitv = b; r.startb = s; r.endf = e; r.chk = c; r.data = d; r.perr = pe; r.ferr = fe;
    return r;
  endfunction

  function automatic logic [15:0] all_outs();
    return {ifc.o_edge_detect, ifc.o_start_bit, ifc.o_data_recovery, ifc.o_end_frame,
            ifc.o_rx_bit, ifc.o_parity_error, ifc.o_frame_error, ifc.o_rx_data};
  endfunction

  task automatic fsm_drive_idle();
    ifc.i_sampling_en         = 1'b0;
    ifc.i_bit_counter_load_en = 1'b0;
    ifc.i_start_bit_wait      = 1'b0;
    ifc.i_data_bit_wait       = 1'b0;
    ifc.i_parity_check        = 1'b0;
    ifc.i_stop_bit_wait       = 1'b0;
  endtask

  // Receive FSM model that sequences the phase inputs from the DUT's pulses
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.o_edge_detect) edge_cnt++;
      if (rst) begin
        fst = F_IDLE;
        fsm_drive_idle();
      end else begin
        ifc.i_bit_counter_load_en = 1'b0;
        case (fst)
          F_IDLE: if (ifc.o_edge_detect) begin
            ifc.i_bit_counter_load_en = 1'b1;
            ifc.i_sampling_en         = 1'b1;
            ifc.i_start_bit_wait      = 1'b1;
            fst = F_START;
          end
          F_START: if (ifc.o_data_recovery) begin
            ifc.i_start_bit_wait = 1'b0;
            if (ifc.o_start_bit) begin
              ifc.i_data_bit_wait = 1'b1;
              fst = F_DATA;
            end else begin
              ifc.i_sampling_en = 1'b0;
              fst = F_IDLE;
            end
          end
          F_DATA: if (ifc.o_data_recovery && ifc.o_end_frame) begin
            ifc.i_data_bit_wait = 1'b0;
            if (ifc.i_upm1) begin
              ifc.i_parity_check = 1'b1;
              fst = F_PAR;
            end else begin
              ifc.i_stop_bit_wait = 1'b1;
              fst = F_STOP;
            end
          end
          F_PAR: if (ifc.o_data_recovery) begin
            ifc.i_parity_check  = 1'b0;
            ifc.i_stop_bit_wait = 1'b1;
            fst = F_STOP;
          end
          default: if (ifc.o_data_recovery) begin
            ifc.i_stop_bit_wait = 1'b0;
            ifc.i_sampling_en   = 1'b0;
            fst = F_IDLE;
          end
        endcase
      end
    end
  end

  // Scoreboard monitor: every recovery pulse consumes one expected record
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ifc.o_data_recovery) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_recovery actual=rx_bit %0b required=no recovery", ifc.o_rx_bit);
        end else begin
          e = expq.pop_front();
          check("rx_bit",    ifc.o_rx_bit,    e.bitv);
          check("start_bit", ifc.o_start_bit, e.startb);
          check("end_frame", ifc.o_end_frame, e.endf);
          if (e.chk) begin
            check("rx_data",      ifc.o_rx_data,      e.data);
            check("parity_error", ifc.o_parity_error, e.perr);
            check("frame_error",  ifc.o_frame_error,  e.ferr);
          end
        end
      end
    end
  end

  task automatic idle_line(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ifc.i_rxd = 1'b1;
    end
  endtask

  // One serial frame; flip_bit inverts cycle 9 of that bit, abort_at pulses reset mid-bit
  task automatic send_frame(input logic [8:0] data, input logic [2:0] ucsz, input logic pen,
                            input logic odd, input logic bad_par, input logic stopb,
                            input int flip_bit, input int abort_at);
    int         n;
    logic       bits[$];
    logic [8:0] dm;
    logic       pbit;
    logic       pe;
    n    = (ucsz == 3'd0) ? 5 : (ucsz == 3'd1) ? 6 : (ucsz == 3'd2) ? 7 : (ucsz == 3'd7) ? 9 : 8;
    dm   = 9'(int'(data) & ((1 << n) - 1));
    pbit = (^dm) ^ odd ^ bad_par;
    pe   = pen && (((^dm) ^ pbit) != odd);
    ifc.i_ucsz = ucsz;
    ifc.i_upm1 = pen;
    ifc.i_upm0 = odd;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(dm[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stopb);
    for (int k = 0; k < bits.size(); k++) begin
      if (abort_at >= 0 && k >= abort_at) break;
      if (k == 0)                 expq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0));
      else if (k <= n)            expq.push_back(mk(bits[k], 1'b0, k == n, 1'b0, 9'h000, 1'b0, 1'b0));
      else if (k < bits.size()-1) expq.push_back(mk(bits[k], 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0));
      else                        expq.push_back(mk(stopb, 1'b0, 1'b0, 1'b1, dm, pe, !stopb));
    end
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        ifc.i_rxd = (k == flip_bit && c == 9) ? ~bits[k] : bits[k];
        if (k == abort_at && c == 8) begin
          #2 rst = 1'b1;
          #1 check("reset_midframe_outputs", all_outs(), 16'h0000);
          ifc.i_rxd = 1'b1;
          @(posedge clk); @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
      end
    end
    idle_line(8);
  endtask

  initial begin
    int   e0;
    logic any;
    ifc.i_rxd  = 1'b1;
    ifc.i_ucsz = 3'b011;
    ifc.i_upm1 = 1'b0;
    ifc.i_upm0 = 1'b0;
    fsm_drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_state", all_outs(), 16'h0000);
    rst = 1'b0;

    e0  = edge_cnt;
    any = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any = any | (|all_outs());
    end
    check("idle_edge_count", edge_cnt - e0, 0);
    check("idle_outputs_nonzero", any, 1'b0);

    send_frame(9'h0A5, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(9'h013, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
    send_frame(9'h013, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
    send_frame(9'h1FF, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);

    // 4-cycle low glitch: edge seen, then a recovered 1 aborts the start
    e0 = edge_cnt;
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      ifc.i_rxd = 1'b0;
    end
    idle_line(40);
    check("glitch_edge_count", edge_cnt - e0, 1);

    send_frame(9'h0C3, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, -1, 4);
    repeat (20) @(negedge clk);
    check("post_reset_outputs", all_outs(), 16'h0000);
    check("post_reset_queue", expq.size(), 0);
    send_frame(9'h05A, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);

`ifdef RX_MAJORITY_VOTE_EN
    send_frame(9'h0F0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
    send_frame(9'h00F, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 2, -1);
`endif

    for (int r = 0; r < 24; r++) begin
      send_frame(9'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0), -1, -1);
    end

    repeat (20) @(posedge clk);
    check("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
